// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter that shares one 32-bit XNOR Fibonacci LFSR among
// N_REQ requesters, handling seeding, lockup protection and warm-up.
//
// Ports:
//   clock      rising-edge clock
//   resetn     asynchronous active-low reset
//   req        per-requester request level, held until granted
//   seed_load  one-cycle pulse, loads seed_value (all-ones -> SEED)
//   seed_value new LFSR seed
//   gnt        registered one-hot grant pulse
//   rnd        granted random word (pre-step LFSR value)
//   rnd_valid  high exactly when gnt != 0
//   rnd_id     index of the granted requester
//   busy       high while discarding warm-up steps
module lfsr_rng_arbiter #(
  parameter int          N_REQ  = 4,
  parameter logic [31:0] SEED   = 32'h007300F6,
  parameter int          WARMUP = 16,
  localparam int         IDW    = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [N_REQ-1:0] req,
  input  logic             seed_load,
  input  logic [31:0]      seed_value,
  output logic [N_REQ-1:0] gnt,
  output logic [31:0]      rnd,
  output logic             rnd_valid,
  output logic [IDW-1:0]   rnd_id,
  output logic             busy
);

  typedef enum logic {
    WARM  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam state_t INIT_ST =
    (WARMUP == 0) ? SERVE : WARM;

  // cnt value on which the final warm-up step is taken
  localparam logic [7:0] LAST =
    (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] r
  );
    return {r[30:0], ~(r[31] ^ r[21] ^ r[1] ^ r[0])};
  endfunction

  state_t             state_q, state_d;
  logic [31:0]        r_q, r_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_d;
  logic [31:0]        rnd_d;
  logic               vld_d;
  logic [IDW-1:0]     id_d;

  logic               found;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     ptr_nx;

  // Rotating priority scan starting at ptr_q
  always_comb begin : arb
    int             k;
    int             t;
    logic [IDW-1:0] idx;
    found  = 1'b0;
    win    = '0;
    k      = 0;
    t      = 0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= N_REQ) k = k - N_REQ;
      idx = k[IDW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    t = int'(win) + 1;
    if (t >= N_REQ) t = 0;
    ptr_nx = t[IDW-1:0];
  end

  always_comb begin : nxt
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    vld_d   = 1'b0;
    rnd_d   = rnd;
    id_d    = rnd_id;
    if (seed_load) begin
      // Seed load cancels any arbitration this cycle
      r_d     = (seed_value == '1) ? SEED : seed_value;
      cnt_d   = '0;
      state_d = INIT_ST;
    end else begin
      unique case (state_q)
        WARM: begin
          r_d   = lfsr_step(r_q);
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST) state_d = SERVE;
        end
        SERVE: begin
          if (found) begin
            gnt_d      = '0;
            gnt_d[win] = 1'b1;
            vld_d      = 1'b1;
            rnd_d      = r_q;
            id_d       = win;
            r_d        = lfsr_step(r_q);
            ptr_d      = ptr_nx;
          end
        end
        default: state_d = INIT_ST;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= INIT_ST;
      r_q       <= SEED;
      cnt_q     <= '0;
      ptr_q     <= '0;
      gnt       <= '0;
      rnd       <= '0;
      rnd_valid <= 1'b0;
      rnd_id    <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt       <= gnt_d;
      rnd       <= rnd_d;
      rnd_valid <= vld_d;
      rnd_id    <= id_d;
    end
  end

  assign busy = (state_q == WARM);

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench for lfsr_rng_arbiter: one instance with no warm-up,
// one with a 16-step warm-up, sharing clock, reset and seed inputs.
module tb_lfsr_rng_arbiter;

  logic        clock;
  logic        resetn;
  logic        seed_load;
  logic [31:0] seed_value;

  logic [3:0]  req0, req16;
  logic [3:0]  gnt0, gnt16;
  logic [31:0] rnd0, rnd16;
  logic        vld0, vld16;
  logic [1:0]  id0, id16;
  logic        busy0, busy16;

  int total;
  int bad;

  lfsr_rng_arbiter #(
    .N_REQ(4), .SEED(32'h007300F6), .WARMUP(0)
  ) dut0 (
    .clock(clock), .resetn(resetn), .req(req0),
    .seed_load(seed_load), .seed_value(seed_value),
    .gnt(gnt0), .rnd(rnd0), .rnd_valid(vld0),
    .rnd_id(id0), .busy(busy0)
  );

  lfsr_rng_arbiter #(
    .N_REQ(4), .SEED(32'h007300F6), .WARMUP(16)
  ) dut16 (
    .clock(clock), .resetn(resetn), .req(req16),
    .seed_load(seed_load), .seed_value(seed_value),
    .gnt(gnt16), .rnd(rnd16), .rnd_valid(vld16),
    .rnd_id(id16), .busy(busy16)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] step(input logic [31:0] r);
    return {r[30:0], ~(r[31] ^ r[21] ^ r[1] ^ r[0])};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] exp;
    logic [3:0]  one;
    total      = 0;
    bad        = 0;
    resetn     = 1'b0;
    seed_load  = 1'b0;
    seed_value = '0;
    req0       = '0;
    req16      = '0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state
    chk("rst_gnt0", 32'(gnt0), 32'h0);
    chk("rst_rnd0", rnd0, 32'h0);
    chk("rst_vld0", 32'(vld0), 32'h0);
    chk("rst_id0", 32'(id0), 32'h0);
    chk("rst_busy0", 32'(busy0), 32'h0);
    chk("rst_busy16", 32'(busy16), 32'h1);

    resetn = 1'b1;
    req0   = 4'b0001;
    req16  = 4'b1111;

    // Two back-to-back grants to requester 0, warm-up runs alongside
    tick();
    chk("a1_gnt", 32'(gnt0), 32'h1);
    chk("a1_rnd", rnd0, 32'h007300F6);
    chk("a1_id", 32'(id0), 32'h0);
    chk("a1_vld", 32'(vld0), 32'h1);
    chk("w1_gnt", 32'(gnt16), 32'h0);
    tick();
    chk("a2_gnt", 32'(gnt0), 32'h1);
    chk("a2_rnd", rnd0, 32'h00E601ED);
    chk("a2_id", 32'(id0), 32'h0);
    chk("w2_gnt", 32'(gnt16), 32'h0);
    req0 = 4'b0000;
    tick();
    chk("a3_gnt", 32'(gnt0), 32'h0);
    chk("a3_vld", 32'(vld0), 32'h0);
    chk("a3_hold", rnd0, 32'h00E601ED);
    chk("w3_gnt", 32'(gnt16), 32'h0);

    for (int k = 4; k <= 16; k++) begin
      tick();
      chk("w_gnt", 32'(gnt16), 32'h0);
      chk("w_busy", 32'(busy16), (k < 16) ? 32'h1 : 32'h0);
    end

    exp = 32'h007300F6;
    for (int k = 0; k < 16; k++) exp = step(exp);
    tick();
    chk("w17_gnt", 32'(gnt16), 32'h1);
    chk("w17_rnd", rnd16, exp);
    chk("w17_id", 32'(id16), 32'h0);
    chk("w17_busy", 32'(busy16), 32'h0);
    req16 = 4'b0000;

    // Illegal all-ones seed with a pending request
    req0       = 4'b0001;
    seed_load  = 1'b1;
    seed_value = 32'hFFFFFFFF;
    tick();
    chk("s1_gnt", 32'(gnt0), 32'h0);
    chk("s1_vld", 32'(vld0), 32'h0);
    seed_load = 1'b0;
    tick();
    chk("s1b_gnt", 32'(gnt0), 32'h1);
    chk("s1b_rnd", rnd0, 32'h007300F6);
    req0 = 4'b0000;

    // Legal seed; requester 1 then gets two words
    seed_load  = 1'b1;
    seed_value = 32'h00E601ED;
    tick();
    chk("s2_vld", 32'(vld0), 32'h0);
    seed_load = 1'b0;
    req0      = 4'b0010;
    tick();
    chk("s2a_gnt", 32'(gnt0), 32'h2);
    chk("s2a_rnd", rnd0, 32'h00E601ED);
    chk("s2a_id", 32'(id0), 32'h1);
    tick();
    chk("s2b_gnt", 32'(gnt0), 32'h2);
    chk("s2b_rnd", rnd0, 32'h01CC03DB);

    // Pointer now at 2; then reset mid-stream
    req0 = 4'b1111;
    tick();
    chk("m_gnt", 32'(gnt0), 32'h4);
    chk("m_id", 32'(id0), 32'h2);
    resetn = 1'b0;
    #1;
    chk("m_rst_gnt", 32'(gnt0), 32'h0);
    chk("m_rst_rnd", rnd0, 32'h0);
    chk("m_rst_vld", 32'(vld0), 32'h0);
    tick();
    resetn = 1'b1;

    // Fairness from a fresh pointer with all requesting
    exp = 32'h007300F6;
    for (int k = 0; k < 8; k++) begin
      tick();
      one = 4'b0001 << (k % 4);
      chk("f_gnt", 32'(gnt0), 32'(one));
      chk("f_id", 32'(id0), 32'(k % 4));
      chk("f_rnd", rnd0, exp);
      exp = step(exp);
    end
    req0 = 4'b0000;
    tick();
    chk("end_vld", 32'(vld0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_arbiter.md
Name: lfsr_rng_arbiter

Overview:
- Owns one 32-bit XNOR Fibonacci LFSR random source and shares it between N_REQ requesters.
- Serves requesters round-robin: each grant delivers exactly one 32-bit word and advances the LFSR by exactly one step.
- Handles seeding, all-ones lockup protection and a post-seed warm-up (discard) phase.
- Sits between the noise/dither consumers and the random source, so no two consumers ever receive the same word.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- SEED, 32'h007300F6, LFSR value at reset and substitute for an illegal seed.
- WARMUP, 16, LFSR steps discarded after reset or seed load before serving (0..255; 0 = serve immediately).

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester request level; held until granted.
- seed_load  in  1  single-cycle pulse: load seed_value.
- seed_value  in  32  new LFSR seed.
- gnt  out  N_REQ  one-hot grant pulse, registered.
- rnd  out  32  granted random word.
- rnd_valid  out  1  rnd/rnd_id valid; high exactly when gnt != 0.
- rnd_id  out  clog2(N_REQ)  index of the granted requester.
- busy  out  1  high while in WARM state.

Behaviour:
- LFSR step function:
  - fb = ~(r[31]^r[21]^r[1]^r[0]).
  - r_next = {r[30:0], fb}.
  - All-ones is the lockup state; it must never be loaded.
- Reset (async, resetn=0):
  - r=SEED; state=WARM; warm counter cnt=0; round-robin pointer ptr=0.
  - gnt=0, rnd=0, rnd_valid=0, rnd_id=0, busy=1.
  - If WARMUP=0, reset state is SERVE and busy=0 instead.
- State WARM:
  - r steps every cycle; cnt increments every cycle.
  - After WARMUP steps (cnt==WARMUP-1 step taken), next state is SERVE and busy drops in the same edge.
  - req is ignored; no grants are issued.
- State SERVE:
  - Cycle t with any req bit set: winner = first set bit scanning ptr, ptr+1, ... mod N_REQ.
  - At edge t+1:
    - gnt = onehot(winner); rnd = r value at cycle t (pre-step); rnd_id = winner; rnd_valid = 1.
    - r steps once; ptr = (winner+1) mod N_REQ.
  - Cycle with no req: r holds, ptr holds, gnt=0, rnd_valid=0, rnd and rnd_id hold their last values.
  - Latency is 1 cycle, req to gnt. At most one grant per cycle; no idle bubble is required between grants.
- Requester rules:
  - A requester drops req in the cycle after it sees its gnt if it wants only one word.
  - If req stays high it is considered again at the next arbitration, subject to round-robin order.
  - A req withdrawn before being granted is simply never served.
- Fairness: with all N_REQ requesting continuously, each requester receives exactly one grant every N_REQ cycles, in index order.
- seed_load (any state, highest priority):
  - At the next edge: r = (seed_value==32'hFFFFFFFF) ? SEED : seed_value; cnt=0.
  - State = WARM (or SERVE if WARMUP=0); busy follows the state.
  - gnt=0 and rnd_valid=0 that edge; any pending arbitration in that cycle is cancelled (not stepped, not granted).
  - ptr is unchanged.
- seed_load and a req in the same cycle: the seed wins; the req is re-arbitrated later.
- Reset asserted mid-grant: all outputs clear asynchronously; nothing issued is replayed.

Test Plan:
- WARMUP=0, reset release, req=4'b0001 held 2 cycles -> gnt=0001 on two consecutive cycles; rnd=0x007300F6 then 0x00E601ED; rnd_id=0 both.
- WARMUP=16, reset release, req=4'b1111 immediately -> busy=1 and gnt=0 for 16 cycles; first gnt=0001 on cycle 17; rnd equals the 17th value of the step sequence from 0x007300F6.
- WARMUP=0, req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000; successive rnd values follow the step sequence with no repeats or skips.
- WARMUP=0, seed_load with seed_value=0xFFFFFFFF while req=0001 -> no gnt that edge; next grant returns rnd=0x007300F6.
- WARMUP=0, seed_load with seed_value=0x00E601ED -> next grant rnd=0x00E601ED, following grant 0x01CC03DB.
- Mid-stream, pull resetn low for 1 cycle while req=1111 -> gnt/rnd/rnd_valid=0 immediately; ptr restarts, so the first post-reset grant is 0001 with rnd=0x007300F6 (WARMUP=0).
